dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the single-port DataMemory. Shares it between

---
 rtl/dmem_arbiter.sv | 90 +++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer sharing one single-port DataMemory
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  A_Req,
  input  logic                  A_Wr,
  input  logic [ADDR_WIDTH-1:0] A_Addr,
  input  logic [DATA_WIDTH-1:0] A_WData,
  output logic                  A_Ack,
  output logic                  A_Err,
  output logic [DATA_WIDTH-1:0] A_RData,
  input  logic                  B_Req,
  input  logic                  B_Wr,
  input  logic [ADDR_WIDTH-1:0] B_Addr,
  input  logic [DATA_WIDTH-1:0] B_WData,
  output logic                  B_Ack,
  output logic                  B_Err,
  output logic [DATA_WIDTH-1:0] B_RData,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemRData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, nextState;
  logic                  selB, wrQ, lastB, misaligned, grantB, anyReq;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [DATA_WIDTH-1:0] wDataQ, aRDataQ, bRDataQ;

  assign anyReq     = A_Req || B_Req;
  assign grantB     = B_Req && (!A_Req || (!FIXED_PRIO && !lastB));
  assign misaligned = addrQ[1:0] != 2'b00;
  assign A_RData    = aRDataQ;
  assign B_RData    = bRDataQ;

  // state register; reset forces IDLE so strobes drop without waiting for a clock
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= nextState;

  // every access is a fixed IDLE -> ACCESS -> RESP walk
  always_comb
    nextState = state == IDLE ? (anyReq ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;

  // memory strobes only in ACCESS (suppressed if misaligned), handshake only in RESP
  always_comb begin
    MemAddress = state == ACCESS ? addrQ : '0;
    MemWData   = state == ACCESS ? wDataQ : '0;
    MemWrite   = state == ACCESS && !misaligned && wrQ;
    MemRead    = state == ACCESS && !misaligned && !wrQ;
    A_Ack      = state == RESP && !selB;
    B_Ack      = state == RESP && selB;
    A_Err      = A_Ack && misaligned;
    B_Err      = B_Ack && misaligned;
  end

  // latch the winning request and remember who was granted for round-robin
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      selB   <= 1'b0;
      wrQ    <= 1'b0;
      addrQ  <= '0;
      wDataQ <= '0;
      lastB  <= 1'b1;
    end else if (state == IDLE && anyReq) begin
      selB   <= grantB;
      wrQ    <= grantB ? B_Wr : A_Wr;
      addrQ  <= grantB ? B_Addr : A_Addr;
      wDataQ <= grantB ? B_WData : A_WData;
      lastB  <= grantB;
    end

  // capture read data (or zero on misalignment) for the winner only
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      aRDataQ <= '0;
      bRDataQ <= '0;
    end else if (state == ACCESS && (misaligned || !wrQ)) begin
      if (selB) bRDataQ <= misaligned ? '0 : MemRData;
      else aRDataQ <= misaligned ? '0 : MemRData;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed tests for dmem_arbiter with a behavioural DataMemory
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        A_Req = 0, A_Wr = 0, B_Req = 0, B_Wr = 0;
  logic [31:0] A_Addr = 0, A_WData = 0, B_Addr = 0, B_WData = 0;
  logic        A_Ack, A_Err, B_Ack, B_Err, MemWrite, MemRead;
  logic [31:0] A_RData, B_RData, MemAddress, MemWData, MemRData;
  logic [31:0] mem [0:255];

  logic        fA_Req = 0, fB_Req = 0;
  logic        fA_Ack, fA_Err, fB_Ack, fB_Err, fMemWrite, fMemRead;
  logic [31:0] fA_RData, fB_RData, fMemAddress, fMemWData;

  int checks = 0, failures = 0;
  int aCyc [4], bCyc [4];
  int na, nb, bothAck, bothStrobe = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .A_Req(A_Req), .A_Wr(A_Wr), .A_Addr(A_Addr), .A_WData(A_WData),
    .A_Ack(A_Ack), .A_Err(A_Err), .A_RData(A_RData),
    .B_Req(B_Req), .B_Wr(B_Wr), .B_Addr(B_Addr), .B_WData(B_WData),
    .B_Ack(B_Ack), .B_Err(B_Err), .B_RData(B_RData),
    .MemAddress(MemAddress), .MemWData(MemWData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemRData(MemRData)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b1)) dutF (
    .Clk(Clk), .Reset_n(Reset_n),
    .A_Req(fA_Req), .A_Wr(1'b0), .A_Addr(32'h0), .A_WData(32'h0),
    .A_Ack(fA_Ack), .A_Err(fA_Err), .A_RData(fA_RData),
    .B_Req(fB_Req), .B_Wr(1'b0), .B_Addr(32'h4), .B_WData(32'h0),
    .B_Ack(fB_Ack), .B_Err(fB_Err), .B_RData(fB_RData),
    .MemAddress(fMemAddress), .MemWData(fMemWData), .MemWrite(fMemWrite),
    .MemRead(fMemRead), .MemRData(32'hABCD0123)
  );

  assign MemRData = mem[MemAddress[9:2]];

  always @(posedge Clk) if (MemWrite) mem[MemAddress[9:2]] <= MemWData;

  always @(negedge Clk) if (MemWrite && MemRead) bothStrobe++;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic doAccess(input bit isB, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic err, output int nWr, output int nRd);
    if (isB) begin B_Req = 1; B_Wr = wr; B_Addr = addr; B_WData = wd; end
    else begin A_Req = 1; A_Wr = wr; A_Addr = addr; A_WData = wd; end
    lat = 0; nWr = 0; nRd = 0; rd = 'x; err = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      tick;
      nWr += int'(MemWrite);
      nRd += int'(MemRead);
      if (isB ? B_Ack : A_Ack) begin
        lat = c;
        rd = isB ? B_RData : A_RData;
        err = isB ? B_Err : A_Err;
        break;
      end
    end
    A_Req = 0; B_Req = 0;
    tick;
  endtask

  task automatic runTie(input int ncyc, input bit dropOnAck);
    A_Req = 1; A_Wr = 0; A_Addr = 0;
    B_Req = 1; B_Wr = 0; B_Addr = 0;
    na = 0; nb = 0; bothAck = 0;
    for (int c = 1; c <= ncyc; c++) begin
      tick;
      if (A_Ack && B_Ack) bothAck++;
      if (A_Ack) begin if (na < 4) aCyc[na] = c; na++; if (dropOnAck) A_Req = 0; end
      if (B_Ack) begin if (nb < 4) bCyc[nb] = c; nb++; if (dropOnAck) B_Req = 0; end
    end
    A_Req = 0; B_Req = 0;
    tick;
  endtask

  task automatic test_reset;
    Reset_n = 0;
    tick; tick;
    Reset_n = 1;
    tick;
    checks++;
    if ({MemWrite, MemRead, A_Ack, B_Ack, A_Err, B_Err} !== 6'b0 || MemAddress !== 0 || MemWData !== 0) begin
      failures++;
      $display("FAIL reset_outputs: strobes/acks=%b addr=%h wdata=%h, required all zero",
               {MemWrite, MemRead, A_Ack, B_Ack, A_Err, B_Err}, MemAddress, MemWData);
    end
    checks++;
    if (A_RData !== 0 || B_RData !== 0) begin
      failures++;
      $display("FAIL reset_rdata: A=%h B=%h, required 0", A_RData, B_RData);
    end
  endtask

  task automatic test_rr_tie;
    runTie(11, 0);
    checks++;
    if (na != 2 || aCyc[0] != 2 || aCyc[1] != 8) begin
      failures++;
      $display("FAIL rr_tie_a: acks=%0d at %0d,%0d, required 2 at 2,8", na, aCyc[0], aCyc[1]);
    end
    checks++;
    if (nb != 2 || bCyc[0] != 5 || bCyc[1] != 11) begin
      failures++;
      $display("FAIL rr_tie_b: acks=%0d at %0d,%0d, required 2 at 5,11", nb, bCyc[0], bCyc[1]);
    end
    checks++;
    if (bothAck != 0) begin
      failures++;
      $display("FAIL rr_tie_both_ack: cycles=%0d, required 0", bothAck);
    end
  endtask

  task automatic test_a_only;
    int lat, nWr, nRd;
    logic [31:0] rd;
    logic err;
    doAccess(0, 1, 32'h4, 32'h11, lat, rd, err, nWr, nRd);
    checks++;
    if (lat != 2 || nWr != 1 || nRd != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL a_write: lat=%0d wr=%0d rd=%0d err=%b, required 2 1 0 0", lat, nWr, nRd, err);
    end
    doAccess(0, 0, 32'h4, 32'h0, lat, rd, err, nWr, nRd);
    checks++;
    if (lat != 2 || nWr != 0 || nRd != 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL a_read_timing: lat=%0d wr=%0d rd=%0d err=%b, required 2 0 1 0", lat, nWr, nRd, err);
    end
    checks++;
    if (rd !== 32'h11) begin
      failures++;
      $display("FAIL a_read_data: got %h, required 00000011", rd);
    end
  endtask

  task automatic test_rr_pointer;
    runTie(5, 1);
    checks++;
    if (nb != 1 || bCyc[0] != 2 || na != 1 || aCyc[0] != 5) begin
      failures++;
      $display("FAIL rr_pointer: B %0d@%0d A %0d@%0d, required B 1@2 A 1@5", nb, bCyc[0], na, aCyc[0]);
    end
  endtask

  task automatic test_fixed_prio;
    int fa = 0, fb = 0, c = 0;
    fA_Req = 1; fB_Req = 1;
    for (int i = 1; i <= 11; i++) begin
      tick;
      fa += int'(fA_Ack);
      fb += int'(fB_Ack);
    end
    checks++;
    if (fa != 4 || fb != 0) begin
      failures++;
      $display("FAIL fixed_starve: A acks=%0d B acks=%0d, required 4 0", fa, fb);
    end
    fA_Req = 0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (fB_Ack) begin c = i; break; end
    end
    checks++;
    if (c != 3) begin
      failures++;
      $display("FAIL fixed_b_after_drop: ack after %0d cycles, required 3", c);
    end
    fB_Req = 0;
    tick;
  endtask

  task automatic test_misaligned;
    int lat, nWr, nRd;
    logic [31:0] rd;
    logic err;
    doAccess(1, 0, 32'h4, 32'h0, lat, rd, err, nWr, nRd);
    checks++;
    if (lat != 2 || rd !== 32'h11 || err !== 1'b0) begin
      failures++;
      $display("FAIL b_read: lat=%0d data=%h err=%b, required 2 00000011 0", lat, rd, err);
    end
    doAccess(1, 1, 32'h6, 32'hDEAD, lat, rd, err, nWr, nRd);
    checks++;
    if (lat != 2 || nWr != 0 || nRd != 0) begin
      failures++;
      $display("FAIL misalign_strobes: lat=%0d wr=%0d rd=%0d, required 2 0 0", lat, nWr, nRd);
    end
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL misalign_resp: err=%b data=%h, required 1 00000000", err, rd);
    end
    doAccess(0, 0, 32'h4, 32'h0, lat, rd, err, nWr, nRd);
    checks++;
    if (rd !== 32'h11) begin
      failures++;
      $display("FAIL misalign_no_write: word 0x4=%h, required 00000011", rd);
    end
  endtask

  task automatic test_reset_mid_access;
    int lat, nWr, nRd;
    logic [31:0] rd;
    logic err;
    doAccess(0, 1, 32'h8, 32'h33, lat, rd, err, nWr, nRd);
    A_Req = 1; A_Wr = 1; A_Addr = 32'h8; A_WData = 32'h55;
    tick;
    checks++;
    if (MemWrite !== 1'b1 || MemAddress !== 32'h8) begin
      failures++;
      $display("FAIL abort_setup: MemWrite=%b addr=%h, required 1 00000008", MemWrite, MemAddress);
    end
    #2 Reset_n = 0;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || MemRead !== 1'b0 || MemAddress !== 32'h0) begin
      failures++;
      $display("FAIL abort_async_drop: MemWrite=%b MemRead=%b addr=%h, required 0 0 0", MemWrite, MemRead, MemAddress);
    end
    A_Req = 0;
    tick;
    Reset_n = 1;
    tick;
    checks++;
    if (A_Ack !== 1'b0 || B_Ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_ack: A_Ack=%b B_Ack=%b, required 0 0", A_Ack, B_Ack);
    end
    doAccess(0, 0, 32'h8, 32'h0, lat, rd, err, nWr, nRd);
    checks++;
    if (lat != 2 || rd !== 32'h33) begin
      failures++;
      $display("FAIL abort_old_data: lat=%0d data=%h, required 2 00000033", lat, rd);
    end
  endtask

  task automatic test_interleave;
    int lat, nWr, nRd;
    logic [31:0] rd;
    logic err;
    for (int i = 0; i < 5; i++) begin
      doAccess(1, 1, 32'(4 * i), 32'(i), lat, rd, err, nWr, nRd);
      doAccess(0, 0, 32'(4 * i), 32'h0, lat, rd, err, nWr, nRd);
      checks++;
      if (lat != 2 || rd !== 32'(i)) begin
        failures++;
        $display("FAIL interleave_word%0d: lat=%0d data=%h, required 2 %h", i, lat, rd, 32'(i));
      end
    end
    checks++;
    if (bothStrobe != 0) begin
      failures++;
      $display("FAIL strobe_exclusive: cycles with both strobes=%0d, required 0", bothStrobe);
    end
  endtask

  initial begin
    test_reset;
    test_rr_tie;
    test_a_only;
    test_rr_pointer;
    test_fixed_prio;
    test_misaligned;
    test_reset_mid_access;
    test_interleave;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
